// File: rtl/rv32_enc_pkg.sv
// rv32_enc_pkg
// Shared definitions for the instruction encode/loader slice: RV32 opcode
// and funct3 constants, the descriptor kind encoding, the halt word, the
// loader state enum, the packed descriptor layout carried through the FIFO
// and the descriptor-to-instruction encoder.
package rv32_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] KIND_R      = 2'b00;
    localparam logic [1:0] KIND_LOAD   = 2'b01;
    localparam logic [1:0] KIND_STORE  = 2'b10;
    localparam logic [1:0] KIND_BRANCH = 2'b11;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    // beq x0,x0,0 : a self loop the core spins on once the program ends
    localparam logic [31:0] HALT_WORD = 32'h0000_0063;

    localparam int DESC_W = 33;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } desc_t;

    // Builds the 32-bit instruction word; fields a class does not use stay 0.
    // For branches the descriptor immediate already holds offset[12:1], so
    // the B-type scatter is taken straight from imm[11:0].
    function automatic logic [31:0] encode(desc_t d);
        logic [31:0] w;
        w = '0;
        case (d.kind)
            KIND_R:     w = {1'b0, d.funct[3], 5'b0, d.rs2, d.rs1, d.funct[2:0], d.rd, OP_R};
            KIND_LOAD:  w = {d.imm, d.rs1, F3_LW, d.rd, OP_LOAD};
            KIND_STORE: w = {d.imm[11:5], d.rs2, d.rs1, F3_SW, d.imm[4:0], OP_STORE};
            default:    w = {d.imm[11], d.imm[9:4], d.rs2, d.rs1, F3_BEQ,
                             d.imm[3:0], d.imm[10], OP_BRANCH};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo
// Small synchronous FIFO holding packed operation descriptors between the
// host handshake and the encoder/write stage.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties FIFO)
//   push, wdata     : write one entry (ignored when full)
//   pop, rdata      : remove head entry (ignored when empty); rdata = head
//   full, empty     : occupancy flags
// Push and pop in the same cycle leave the occupancy unchanged.
module enc_fifo
    import rv32_enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DESC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader
// Accepts decoded operation descriptors (R-type ALU, lw, sw, beq), encodes
// each into an RV32 instruction word and writes the words to consecutive
// instruction-memory addresses starting at a run's base address.
// Optional feature macro: INSTR_LOADER_HALT_EN -- when defined, a run ends by
// appending beq x0,x0,0 after the last descriptor's word.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   start, base               : begin a run at base (word aligned)
//   finish                    : no more descriptors for this run
//   in_valid/in_ready, in_*   : descriptor handshake and fields
//   imem_stall                : memory cannot take a write this cycle
//   imem_we/addr/wdata        : registered instruction-memory write port
//   busy, done, wrapped, words: run status (done is a one-cycle pulse)
module instr_encode_loader
    import rv32_enc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [3:0]        in_funct,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    input  logic              imem_stall,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W-1:0] words
);

    state_t            state;
    state_t            state_nxt;
    logic              fin_flag;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    desc_t             in_desc;
    desc_t             head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              wr_fire;
    logic [31:0]       wr_data;
    logic              drained;
`ifdef INSTR_LOADER_HALT_EN
    logic              halt_sent;
    logic              halt_go;
`endif

    assign in_desc  = {in_kind, in_funct, in_rd, in_rs1, in_rs2, in_imm};
    assign in_ready = (state == ST_RUN) && !fifo_full && !fin_flag;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_RUN) && !fifo_empty && !imem_stall;
    assign drained  = fin_flag && fifo_empty;
    assign addr_inc = addr + ADDR_W'(4);

`ifdef INSTR_LOADER_HALT_EN
    assign halt_go = (state == ST_HALT) && !halt_sent && !imem_stall;
    assign wr_fire = pop || halt_go;
    assign wr_data = pop ? encode(head) : HALT_WORD;
`else
    assign wr_fire = pop;
    assign wr_data = encode(head);
`endif

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DESC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_desc),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs. A run ends once finish has been seen and
    // the FIFO is empty; the last pop's word is already in the output
    // register, so done lands the cycle after that final write.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (drained) begin
`ifdef INSTR_LOADER_HALT_EN
                    state_nxt = ST_HALT;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
            ST_HALT: begin
                busy = 1'b1;
`ifdef INSTR_LOADER_HALT_EN
                if (halt_sent) begin
                    state_nxt = ST_DONE;
                end
`else
                state_nxt = ST_DONE;
`endif
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Run bookkeeping and the registered memory write. imem_we is cleared
    // every cycle so each word is presented for exactly one cycle; the
    // address counter wraps naturally at 2^ADDR_W and flags it.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            words      <= '0;
            wrapped    <= 1'b0;
            fin_flag   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if ((state == ST_IDLE) && start) begin
                addr     <= {base[ADDR_W-1:2], 2'b00};
                words    <= '0;
                wrapped  <= 1'b0;
                fin_flag <= 1'b0;
            end
            if ((state == ST_RUN) && finish) begin
                fin_flag <= 1'b1;
            end
            if (wr_fire) begin
                imem_we    <= 1'b1;
                imem_addr  <= addr;
                imem_wdata <= wr_data;
                addr       <= addr_inc;
                words      <= words + 1'b1;
                if (addr_inc == '0) begin
                    wrapped <= 1'b1;
                end
            end
        end
    end

`ifdef INSTR_LOADER_HALT_EN
    // Remembers that the halt word has gone out so HALT leaves one cycle
    // after that write is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_sent <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            halt_sent <= 1'b0;
        end else if (halt_go) begin
            halt_sent <= 1'b1;
        end
    end
`endif

endmodule
